// File: rtl/exe_div_iter.sv
// -----------------------------------------------------------------------------
// exe_div_iter
//   Iterative restoring divider for the EXE stage. It produces one quotient bit
//   per cycle. A divide is launched with a start pulse and its result is
//   presented with a one-cycle valid pulse. The flush input aborts the divide
//   in flight. A zero divisor finishes in a single cycle and raises
//   div_by_zero.
//
//   Optional feature: define EXE_DIV_SIGNED_EN to enable signed division when
//   op=1. The divider then works on operand magnitudes and applies the sign
//   fix-up as the result registers load. Without the macro, op is ignored and
//   every divide is unsigned.
// -----------------------------------------------------------------------------
module exe_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic             op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // The partial remainder stays below the divisor between steps, so it needs
  // only WIDTH register bits. The shifted value seen by the trial subtraction
  // is WIDTH+1 bits wide.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;   // dividend shifts out of the top, quotient shifts in at the bottom
  logic [WIDTH-1:0] dsr_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  logic             accept;
  logic             last_step;

  // A start is accepted only outside DIV, and only when flush is not asserted.
  assign accept    = start & ~flush & (state != S_DIV);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

`ifdef EXE_DIV_SIGNED_EN
  logic dvd_neg;
  logic dsr_neg;
  logic neg_q;
  logic neg_r;

  assign dvd_neg = op & dividend[WIDTH-1];
  assign dsr_neg = op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dsr_mag = dsr_neg ? -divisor  : divisor;

  // Capture the result signs when a divide is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dvd_neg ^ dsr_neg;
      neg_r <= dvd_neg;
    end
  end

  // Sign fix-up applied as the final step's result enters the output registers.
  // MIN/-1 gives a magnitude of 2^(WIDTH-1). Negating it yields MIN again.
  assign quo_fix = neg_q ? -step_quo : step_quo;
  assign rem_fix = neg_r ? -step_rem : step_rem;
`else
  logic unused_op;

  assign unused_op = op;
  assign dvd_mag   = dividend;
  assign dsr_mag   = divisor;
  assign quo_fix   = step_quo;
  assign rem_fix   = step_rem;
`endif

  // One restoring step: shift {rem, q} left by one bit, then trial-subtract the divisor.
  always_comb begin
    // NOTE: every output of a combinational block is given a value on every
    // path (here, up front) so that no latch is inferred.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    step_rem = shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      step_rem = trial[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here is sequential and assigned with <=, so every
    // register samples its inputs from before the clock edge.
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      // Abort: return to idle. Any previous result stays visible.
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        S_DIV: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            valid     <= 1'b1;
            quotient  <= quo_fix;
            remainder <= rem_fix;
          end
        end

        // IDLE and DONE both accept a new divide. A start in DONE is a
        // back-to-back issue.
        default: begin
          cnt <= '0;
          if (start) begin
            if (divisor == '0) begin
              state       <= S_DONE;
              busy        <= 1'b0;
              valid       <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= S_DIV;
              busy        <= 1'b1;
              valid       <= 1'b0;
              rem_q       <= '0;
              quo_q       <= dvd_mag;
              dsr_q       <= dsr_mag;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
